// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg
// Shared definitions for the countdown timer: FSM state encoding and the
// BCD digit limits used by the keypad shift-in and the borrow chain.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// bcd_down_digit
// One BCD digit of a down-counter. A borrow request decrements the digit;
// from zero it wraps to WRAP and passes the borrow on to the next digit.
// A load overrides any decrement in the same cycle.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset, clears the digit
//   i_load       in   load i_load_val this cycle
//   i_load_val   in   value to load (4-bit BCD)
//   i_borrow_in  in   decrement request from the less significant digit
//   o_borrow_out out  decrement request for the more significant digit
//   o_value      out  current digit value
module bcd_down_digit #(
  parameter logic [3:0] WRAP = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_borrow_in,
  output logic       o_borrow_out,
  output logic [3:0] o_value
);

  logic [3:0] r_value;

  // Borrow propagates only when this digit is at zero and is being decremented.
  assign o_borrow_out = i_borrow_in && (r_value == 4'd0);
  assign o_value      = r_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_value <= 4'd0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_borrow_in) begin
      r_value <= (r_value == 4'd0) ? WRAP : (r_value - 4'd1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
// Counts an M:SS BCD cook time down by one second on every rising edge of
// the selected time-base pulse stream. Digits are keyed in while idle;
// start/stop strobes run, pause, resume and clear the count.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset, clears all state
//   tick_in      in   time-base level; each rising edge is one count
//   digit        in   keypad digit 0..9
//   digit_valid  in   one-cycle strobe qualifying digit
//   start        in   one-cycle strobe: begin or resume counting
//   stop         in   one-cycle strobe: pause; again while paused clears
//   min_ones     out  BCD minutes digit
//   sec_tens     out  BCD tens-of-seconds digit
//   sec_ones     out  BCD seconds digit
//   running      out  high while counting (magnetron enable)
//   done         out  one-cycle pulse when the count reaches 0:00
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_in,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done
);

  localparam logic [3:0] MIN_LIMIT = 4'(MAX_MIN);

  state_t                 r_state;
  logic                   r_running;
  logic                   r_done;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_tick_prev;

  logic       w_tick_edge;
  logic       w_dec;
  logic       w_at_one;
  logic       w_nonzero;
  logic       w_shift;
  logic       w_clear;
  logic       w_load;
  logic       w_borrow_ones;
  logic       w_borrow_tens;
  logic       w_borrow_min;
  logic [3:0] w_min;
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [3:0] w_min_load;
  logic [3:0] w_tens_load;
  logic [3:0] w_ones_load;

  // Synchroniser chain followed by a rising-edge detect on its last stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync      <= '0;
      r_tick_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], tick_in};
      r_tick_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_tick_edge = r_sync[SYNC_STAGES-1] && !r_tick_prev;

  // Edges outside RUN are simply dropped.
  assign w_dec     = (r_state == ST_RUN) && w_tick_edge;
  assign w_at_one  = (w_min == 4'd0) && (w_tens == 4'd0) && (w_ones == 4'd1);
  assign w_nonzero = (w_min != 4'd0) || (w_tens != 4'd0) || (w_ones != 4'd0);

  // A seconds digit above 5 cannot move into the tens position.
  assign w_shift = (r_state == ST_IDLE) && digit_valid &&
                   (digit <= DIGIT_MAX) && (w_ones <= SEC_TENS_MAX);
  assign w_clear = (r_state == ST_PAUSED) && stop;
  assign w_load  = w_shift || w_clear;

  assign w_ones_load = w_clear ? 4'd0 : digit;
  assign w_tens_load = w_clear ? 4'd0 : w_ones;
  assign w_min_load  = w_clear ? 4'd0 :
                       ((w_tens > MIN_LIMIT) ? MIN_LIMIT : w_tens);

  bcd_down_digit #(.WRAP(DIGIT_MAX)) u_sec_ones (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_load),
    .i_load_val   (w_ones_load),
    .i_borrow_in  (w_dec),
    .o_borrow_out (w_borrow_ones),
    .o_value      (w_ones)
  );

  bcd_down_digit #(.WRAP(SEC_TENS_MAX)) u_sec_tens (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_load),
    .i_load_val   (w_tens_load),
    .i_borrow_in  (w_borrow_ones),
    .o_borrow_out (w_borrow_tens),
    .o_value      (w_tens)
  );

  // The minutes digit never borrows in practice: RUN always leaves at 0:00.
  bcd_down_digit #(.WRAP(MIN_LIMIT)) u_min_ones (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_load),
    .i_load_val   (w_min_load),
    .i_borrow_in  (w_borrow_tens),
    .o_borrow_out (w_borrow_min),
    .o_value      (w_min)
  );

  // Control FSM with registered running/done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!stop && start && w_nonzero) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          // Reaching 0:00 beats a simultaneous stop.
          if (w_dec && w_at_one) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (stop) begin
            r_state   <= ST_PAUSED;
            r_running <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (stop) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end else if (start) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign min_ones = w_min;
  assign sec_tens = w_tens;
  assign sec_ones = w_ones;
  assign running  = r_running;
  assign done     = r_done;

endmodule
